// File: rtl/mac_operand_sequencer.sv
// Operand FIFO and burst sequencer feeding the sequential MAC.
// Issues one pair per cycle and flags when sum_q holds a complete burst.
module mac_operand_sequencer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int CNTW  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic                     in_last,
    input  logic                     hold,
    output logic [WIDTH-1:0]         acc_a,
    output logic [WIDTH-1:0]         acc_b,
    output logic                     acc_en,
    output logic                     burst_done,
    output logic [CNTW-1:0]          burst_len,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic             mem_l [DEPTH];

    logic [AW-1:0]   wptr, rptr;
    logic [AW:0]     count;
    logic [CNTW-1:0] cnt;
    logic            full, empty, push, pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = !full;
    assign push     = in_valid && !full;

    // Payload storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wptr] <= in_a;
            mem_b[wptr] <= in_b;
            mem_l[wptr] <= in_last;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) state_nxt = RUN;
            end
            RUN: begin
                pop = !empty && !hold;
                if (pop && mem_l[rptr]) state_nxt = FLUSH;
            end
            FLUSH: begin
                state_nxt = DONE;
            end
            DONE: begin
                state_nxt = empty ? IDLE : RUN;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_a  <= '0;
            acc_b  <= '0;
            acc_en <= 1'b0;
            cnt    <= '0;
        end else begin
            acc_en <= pop;
            if (pop) begin
                acc_a <= mem_a[rptr];
                acc_b <= mem_b[rptr];
            end
            // Counter saturates rather than wrapping on very long bursts.
            if (state == DONE)
                cnt <= '0;
            else if (pop && (cnt != '1))
                cnt <= cnt + 1'b1;
        end
    end

    assign burst_done = (state == DONE);
    assign burst_len  = burst_done ? cnt : '0;
    assign fifo_count = count;

endmodule
